// File: rtl/key_mix_seq_if.sv
// Bus bundle for the key-mix stage: key-bank write port, session control,
// input beat handshake and registered output handshake toward the S-box stage.
interface key_mix_seq_if #(
  parameter int unsigned W      = 48,
  parameter int unsigned RIDX_W = 4
) ();

  logic              key_wr_en;
  logic [RIDX_W-1:0] key_wr_addr;
  logic [W-1:0]      key_wr_data;
  logic              start;
  logic              decrypt;
  logic              in_valid;
  logic [W-1:0]      in_data;
  logic              in_ready;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic [RIDX_W-1:0] out_round;
  logic              out_ready;
  logic              busy;
  logic              done;

  // Driver side: key schedule, controller and downstream ready
  modport master (
    output key_wr_en, key_wr_addr, key_wr_data, start, decrypt, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_round, busy, done
  );

  // Key-mix stage side
  modport slave (
    input  key_wr_en, key_wr_addr, key_wr_data, start, decrypt, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_round, busy, done
  );

endinterface

// File: rtl/key_mix_seq.sv
// Sequential expansion/subkey XOR stage. Holds ROUNDS subkeys and mixes one
// data beat per round, walking the bank forward (encrypt) or backward (decrypt).
module key_mix_seq #(
  parameter int unsigned W      = 48,
  parameter int unsigned ROUNDS = 16,
  parameter int unsigned RIDX_W = 4
) (
  input logic          clk,
  input logic          rst,
  key_mix_seq_if.slave bus
);

  localparam int unsigned CntW = RIDX_W + 1;
  localparam logic [RIDX_W-1:0] LastIdx = RIDX_W'(ROUNDS - 1);
  localparam logic [CntW-1:0]   LastCnt = CntW'(ROUNDS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e            state_q, state_d;
  logic [W-1:0]      bank_q [ROUNDS];
  logic [W-1:0]      bank_d [ROUNDS];
  logic [RIDX_W-1:0] idx_q, idx_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              mode_q, mode_d;
  logic              out_valid_q, out_valid_d;
  logic [W-1:0]      out_data_q, out_data_d;
  logic [RIDX_W-1:0] out_round_q, out_round_d;
  logic              done_q, done_d;

  logic              in_ready;
  logic              accept;
  logic [W-1:0]      key_sel;

  // One-deep output register: take a new beat whenever the slot is empty or draining
  always_comb begin
    in_ready = (state_q == StRun) && (!out_valid_q || bus.out_ready);
    accept   = in_ready && bus.in_valid;
  end

  // Subkey read mux; compare-based so the address width need not match the bank depth
  always_comb begin
    key_sel = '0;
    for (int i = 0; i < int'(ROUNDS); i++) begin
      if (idx_q == RIDX_W'(i)) key_sel = bank_q[i];
    end
  end

  // Next-state logic for the session FSM, key bank and output register
  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_round_d = out_round_q;
    done_d      = 1'b0;

    case (state_q)
      StIdle: begin
        // Addresses at or beyond ROUNDS match no entry and are dropped
        for (int i = 0; i < int'(ROUNDS); i++) begin
          if (bus.key_wr_en && (bus.key_wr_addr == RIDX_W'(i))) bank_d[i] = bus.key_wr_data;
        end
        if (bus.start) begin
          mode_d  = bus.decrypt;
          idx_d   = bus.decrypt ? LastIdx : '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end

      StRun: begin
        if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
        if (accept) begin
          out_data_d  = bus.in_data ^ key_sel;
          out_round_d = idx_q;
          out_valid_d = 1'b1;
          cnt_d       = cnt_q + 1'b1;
          // Index stops on the last round rather than stepping past the bank
          if (cnt_q == LastCnt) begin
            state_d = StDrain;
          end else begin
            idx_d = mode_q ? (idx_q - 1'b1) : (idx_q + 1'b1);
          end
        end
      end

      StDrain: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          done_d      = 1'b1;
          state_d     = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; reset also wipes the key bank
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      for (int i = 0; i < int'(ROUNDS); i++) bank_q[i] <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_round_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_round_q <= out_round_d;
      done_q      <= done_d;
    end
  end

  // Drive interface outputs from registered state
  always_comb begin
    bus.in_ready  = in_ready;
    bus.out_valid = out_valid_q;
    bus.out_data  = out_data_q;
    bus.out_round = out_round_q;
    bus.busy      = (state_q != StIdle);
    bus.done      = done_q;
  end

endmodule

// File: tb/tb_key_mix_seq.sv
// Directed bench for key_mix_seq with an expected-beat queue checked at each
// output handshake. RIDX_W is widened to 5 so an out-of-range address (16) exists.
module tb_key_mix_seq;

  localparam int unsigned W      = 48;
  localparam int unsigned ROUNDS = 16;
  localparam int unsigned RIDX_W = 5;

  typedef struct packed {
    logic [W-1:0]      data;
    logic [RIDX_W-1:0] round;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  key_mix_seq_if #(.W(W), .RIDX_W(RIDX_W)) bus ();

  key_mix_seq #(.W(W), .ROUNDS(ROUNDS), .RIDX_W(RIDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  exp_t         exp_q[$];
  exp_t         mon_e;
  logic [W-1:0] tb_bank [ROUNDS];
  int           n_vec = 0;
  int           n_err = 0;
  int           done_cnt = 0;
  int           sess_done0 = 0;
  bit           sess_dec = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Output monitor: every handshake must match the oldest expected beat
  always @(negedge clk) begin
    if (!rst && bus.done) done_cnt++;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_beat", 64'(exp_q.size()), 64'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_data", 64'(bus.out_data), 64'(mon_e.data));
        check("out_round", 64'(bus.out_round), 64'(mon_e.round));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_key(input logic [RIDX_W-1:0] a, input logic [W-1:0] d);
    bus.key_wr_en   = 1'b1;
    bus.key_wr_addr = a;
    bus.key_wr_data = d;
    tick();
    bus.key_wr_en = 1'b0;
    if (int'(a) < int'(ROUNDS)) tb_bank[a[3:0]] = d;
  endtask

  task automatic start_session(input bit dec, input bit wr, input logic [RIDX_W-1:0] wa,
                               input logic [W-1:0] wd);
    sess_done0  = done_cnt;
    sess_dec    = dec;
    bus.start   = 1'b1;
    bus.decrypt = dec;
    if (wr) begin
      bus.key_wr_en   = 1'b1;
      bus.key_wr_addr = wa;
      bus.key_wr_data = wd;
    end
    tick();
    bus.start     = 1'b0;
    bus.decrypt   = !dec;
    bus.key_wr_en = 1'b0;
    if (wr && int'(wa) < int'(ROUNDS)) tb_bank[wa[3:0]] = wd;
    check("busy_after_start", 64'(bus.busy), 64'd1);
  endtask

  task automatic send(input logic [W-1:0] d, input int k, output int waits);
    logic [RIDX_W-1:0] r;
    exp_t              e;
    r       = sess_dec ? RIDX_W'(int'(ROUNDS) - 1 - k) : RIDX_W'(k);
    e.data  = d ^ tb_bank[r[3:0]];
    e.round = r;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    waits = 0;
    @(negedge clk);
    while (!bus.in_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 64'(waits), 64'd0);
      bus.in_valid = 1'b0;
      return;
    end
    exp_q.push_back(e);
    tick();
    bus.in_valid = 1'b0;
    check("lat_valid", 64'(bus.out_valid), 64'd1);
    check("lat_round", 64'(bus.out_round), 64'(r));
    check("lat_data", 64'(bus.out_data), 64'(e.data));
  endtask

  task automatic finish_session();
    int t;
    t = 0;
    while (!bus.done && t < 40) begin
      tick();
      t++;
    end
    check("done_seen", 64'(bus.done), 64'd1);
    tick();
    check("done_one_cycle", 64'(bus.done), 64'd0);
    check("busy_idle", 64'(bus.busy), 64'd0);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("done_count", 64'(done_cnt - sess_done0), 64'd1);
  endtask

  initial begin
    int w;
    int d1;
    logic [W-1:0] sd;
    logic [RIDX_W-1:0] sr;

    bus.key_wr_en   = 1'b0;
    bus.key_wr_addr = '0;
    bus.key_wr_data = '0;
    bus.start       = 1'b0;
    bus.decrypt     = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.out_ready   = 1'b1;
    for (int i = 0; i < int'(ROUNDS); i++) tb_bank[i] = '0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_round", 64'(bus.out_round), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    rst = 1'b0;

    // Key load, plus an out-of-range write that must be dropped
    for (int k = 0; k < int'(ROUNDS); k++) write_key(RIDX_W'(k), 48'h0000_0000_0001 << k);
    write_key(RIDX_W'(16), 48'hDEAD_BEEF_CAFE);

    // in_valid while idle is ignored
    bus.in_valid = 1'b1;
    bus.in_data  = '1;
    @(negedge clk);
    check("idle_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    check("idle_out_valid", 64'(bus.out_valid), 64'd0);
    bus.in_valid = 1'b0;

    // Encrypt session with ignored write/start during RUN
    start_session(1'b0, 1'b0, '0, '0);
    for (int k = 0; k < int'(ROUNDS); k++) begin
      if (k == 1) begin
        bus.key_wr_en   = 1'b1;
        bus.key_wr_addr = RIDX_W'(3);
        bus.key_wr_data = 48'hABCD_EF01_2345;
        bus.start       = 1'b1;
        bus.decrypt     = 1'b1;
      end
      send(48'hFFFF_FFFF_FFFF, k, w);
      bus.key_wr_en = 1'b0;
      bus.start     = 1'b0;
      check("enc_no_wait", 64'(w), 64'd0);
    end
    finish_session();

    // Decrypt session with a 5-cycle downstream stall
    start_session(1'b1, 1'b0, '0, '0);
    for (int k = 0; k < int'(ROUNDS); k++) begin
      send('0, k, w);
      if (k > 5) check("dec_throughput", 64'(w), 64'd0);
      if (k == 5) begin
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = '0;
        sd = bus.out_data;
        sr = bus.out_round;
        repeat (5) begin
          @(negedge clk);
          check("stall_in_ready", 64'(bus.in_ready), 64'd0);
          tick();
          check("stall_valid", 64'(bus.out_valid), 64'd1);
          check("stall_data", 64'(bus.out_data), 64'(sd));
          check("stall_round", 64'(bus.out_round), 64'(sr));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
      end
    end
    finish_session();

    // Reset after 7 beats aborts the session and clears the bank
    start_session(1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 7; k++) send({16'(k), 32'($urandom)}, k, w);
    d1  = done_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check("abort_out_data", 64'(bus.out_data), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_in_ready", 64'(bus.in_ready), 64'd0);
    exp_q.delete();
    for (int i = 0; i < int'(ROUNDS); i++) tb_bank[i] = '0;
    repeat (4) tick();
    check("abort_no_done", 64'(done_cnt - d1), 64'd0);

    // Zeroed bank: outputs equal inputs
    start_session(1'b0, 1'b0, '0, '0);
    for (int k = 0; k < int'(ROUNDS); k++) send({16'($urandom), 32'($urandom)}, k, w);
    finish_session();

    // Same-cycle write and start: session sees the new key
    start_session(1'b0, 1'b1, '0, 48'h1234_5678_9ABC);
    send('0, 0, w);
    check("wr_start_first", 64'(bus.out_data), 64'h0000_1234_5678_9ABC);
    for (int k = 1; k < int'(ROUNDS); k++) send({16'($urandom), 32'($urandom)}, k, w);
    finish_session();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/key_mix_seq.md
Name: key_mix_seq

Overview:
- Parametrised, sequential successor to the combinational expansion/subkey XOR stage in the DES datapath.
- Holds a bank of ROUNDS round subkeys, loaded by the key schedule.
- Steps through one cipher session of ROUNDS data beats. Each accepted beat is XORed with the subkey for the current round.
- Round order is forward for encrypt and reversed for decrypt. Output is registered and uses a valid/ready handshake toward the S-box stage.

Parameters:
- W, 48, data and subkey width in bits
- ROUNDS, 16, number of subkeys and beats per session (2..2^RIDX_W)
- RIDX_W, 4, width of round index and key address

Ports:
- clk  input  1  rising-edge clock (single clock domain)
- rst  input  1  synchronous, active-high reset
- key_wr_en  input  1  write key_wr_data into bank[key_wr_addr]
- key_wr_addr  input  RIDX_W  subkey bank address
- key_wr_data  input  W  subkey value
- start  input  1  single-cycle pulse; begins a session when idle
- decrypt  input  1  sampled with start; 1 = reverse subkey order
- in_valid  input  1  input beat valid
- in_data  input  W  expanded half-block (E output)
- in_ready  output  1  beat accepted when in_valid && in_ready
- out_valid  output  1  out_data valid
- out_data  output  W  in_data XOR selected subkey
- out_round  output  RIDX_W  subkey index used for out_data
- out_ready  input  1  downstream accepts when out_valid && out_ready
- busy  output  1  session in progress (state != IDLE)
- done  output  1  one-cycle pulse when a session's last beat is consumed

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - state=IDLE; all bank entries = 0.
  - out_valid=0, out_data=0, out_round=0, busy=0, done=0, in_ready=0.
  - Round counter = 0; mode register = 0.
  - Reset mid-session aborts the session; no done pulse is generated.
- State machine:
  - IDLE:
    - in_ready=0.
    - key_wr_en writes the bank (takes effect next cycle).
    - start=1 latches decrypt into the mode register and sets idx = 0 (encrypt) or ROUNDS-1 (decrypt), then moves to RUN.
    - If start and key_wr_en are asserted in the same cycle, the write completes and the session uses the new value.
  - RUN:
    - in_ready = !out_valid || out_ready (one-deep output register, no bubble under continuous flow).
    - On accept:
      - out_data <= in_data ^ bank[idx]; out_round <= idx; out_valid <= 1.
      - idx steps +1 (encrypt) or -1 (decrypt).
      - beat count increments.
    - On the ROUNDS-th accept, move to DRAIN.
  - DRAIN:
    - in_ready=0.
    - When out_valid && out_ready: out_valid <= 0, done <= 1 for one cycle, move to IDLE.
- Output register:
  - If not accepting a new beat, out_valid clears on out_valid && out_ready.
  - out_data and out_round hold their value while out_valid && !out_ready (stable under backpressure).
- Latency: 1 cycle from accept to out_valid.
- Ignored inputs:
  - start outside IDLE is ignored.
  - key_wr_en outside IDLE is ignored; the bank is frozen during a session.
  - in_valid in IDLE or DRAIN is ignored.
  - The decrypt input only matters in the start cycle.
- Width rules:
  - Pure bitwise XOR; no carry.
  - key_wr_addr >= ROUNDS is ignored (no write).
- Index boundaries: idx never wraps within a session. Encrypt ends at ROUNDS-1, decrypt ends at 0. The final step is not applied.

Test Plan:
- Encrypt session:
  - Setup: load bank[k] = 48'h0000_0000_0001 << k; start with decrypt=0; feed 16 beats of in_data=48'hFFFF_FFFF_FFFF with out_ready=1.
  - Required: 16 outputs of FFFF_FFFF_FFFF ^ (1<<k), out_round 0..15 in order, beat k appearing 1 cycle after its accept, then a single done pulse and busy=0.
- Decrypt order:
  - Setup: same bank; decrypt=1; in_data=0.
  - Required: out_data = 1<<15, 1<<14, ..., 1, with out_round 15..0.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles mid-session.
  - Required: out_valid stays high, out_data/out_round stay stable, in_ready=0, no beats lost or duplicated. After release, throughput is 1 beat/cycle.
- Ignored controls:
  - Stimulus: key_wr_en to addr 3 with 48'hABCD_EF01_2345 during RUN; start during RUN.
  - Required: bank[3] unchanged and the session is unaffected. A write in IDLE with addr=16 does nothing.
- Reset mid-session:
  - Stimulus: assert rst after 7 beats.
  - Required: next cycle out_valid=0, busy=0, done never pulses, every bank entry reads back as 0 via a subsequent session.
- Same-cycle write+start:
  - Stimulus: in IDLE, key_wr_en to addr 0 with 48'h1234_5678_9ABC together with start (decrypt=0); first beat in_data=0.
  - Required: first out_data = 48'h1234_5678_9ABC.
